// File: rtl/cpu_defs_pkg.sv
// Shared opcode constants, FSM state encoding and control-word layout for the
// instruction-sequencing control unit.
package cpu_defs_pkg;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpHalt = 5'b11111;

  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StT5   = 3'd5,
    StT6   = 3'd6,
    StHalt = 3'd7
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic mdr_out;
    logic mar_enable;
    logic z_enable;
    logic pc_enable;
    logic mdr_enable;
    logic ir_enable;
    logic y_enable;
    logic pc_increment;
    logic read;
    logic lo_enable;
    logic hi_enable;
  } ctrl_t;

  // Register-to-register ops this phase can execute.
  function automatic logic op_supported(input logic [4:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
      OpDiv, OpMul, OpNeg, OpNot: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

  function automatic logic op_is_unary(input logic [4:0] op);
    return (op == OpNeg) || (op == OpNot);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit to datapath bundle: instruction/handshake inputs and all
// register, memory and bus-drive controls.
interface control_unit_if;

  logic [31:0] ir;
  logic        mem_ready;
  logic        stop;

  logic        pc_out;
  logic        zlo_out;
  logic        zhi_out;
  logic        mdr_out;
  logic        mar_enable;
  logic        z_enable;
  logic        pc_enable;
  logic        mdr_enable;
  logic        ir_enable;
  logic        y_enable;
  logic        pc_increment;
  logic        read;
  logic        lo_enable;
  logic        hi_enable;
  logic [4:0]  op_code;
  logic [15:0] r_out;
  logic [15:0] r_in;
  logic        run;
  logic        illegal;

  modport master (
    input  ir, mem_ready, stop,
    output pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, pc_enable,
           mdr_enable, ir_enable, y_enable, pc_increment, read, lo_enable, hi_enable,
           op_code, r_out, r_in, run, illegal
  );

  modport slave (
    output ir, mem_ready, stop,
    input  pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, pc_enable,
           mdr_enable, ir_enable, y_enable, pc_increment, read, lo_enable, hi_enable,
           op_code, r_out, r_in, run, illegal
  );

endinterface

// File: rtl/reg_select.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module reg_select (
  input  logic [3:0]  sel_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: T0-T2 fetch, T3 decode, T4-T6 register-to-register
// execute, with a terminal HALT state left only through clr.
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master ctrl_io
);

  state_e      state_q, state_d;
  logic        active_q;
  logic        illegal_q, illegal_d;
  ctrl_t       ctrl;
  logic [4:0]  op_code;
  logic [3:0]  out_sel;
  logic        out_en;
  logic        in_en;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        unused_ir;

  assign opcode    = ctrl_io.ir[31:27];
  assign ra        = ctrl_io.ir[26:23];
  assign rb        = ctrl_io.ir[22:19];
  assign rc        = ctrl_io.ir[18:15];
  assign unused_ir = ^ctrl_io.ir[14:0];

  // active_q keeps outputs quiet between clr release and the first clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StT0;
      active_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= 1'b1;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctrl      = '0;
    op_code   = '0;
    out_sel   = '0;
    out_en    = 1'b0;
    in_en     = 1'b0;
    if (active_q) begin
      unique case (state_q)
        StT0: begin
          ctrl.pc_out       = 1'b1;
          ctrl.mar_enable   = 1'b1;
          ctrl.pc_increment = 1'b1;
          state_d           = StT1;
        end
        StT1: begin
          ctrl.read       = 1'b1;
          ctrl.mdr_enable = 1'b1;
          if (ctrl_io.mem_ready) begin
            state_d = StT2;
          end
        end
        StT2: begin
          ctrl.mdr_out   = 1'b1;
          ctrl.ir_enable = 1'b1;
          state_d        = StT3;
        end
        StT3: begin
          if (opcode == OpHalt) begin
            state_d = StHalt;
          end else if (op_supported(opcode)) begin
            out_sel       = rb;
            out_en        = 1'b1;
            ctrl.y_enable = 1'b1;
            state_d       = StT4;
          end else begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        end
        StT4: begin
          op_code       = opcode;
          ctrl.z_enable = 1'b1;
          out_sel       = op_is_unary(opcode) ? rb : rc;
          out_en        = 1'b1;
          state_d       = StT5;
        end
        StT5: begin
          ctrl.zlo_out = 1'b1;
          if (op_is_muldiv(opcode)) begin
            ctrl.lo_enable = 1'b1;
            state_d        = StT6;
          end else begin
            in_en   = 1'b1;
            state_d = ctrl_io.stop ? StHalt : StT0;
          end
        end
        StT6: begin
          ctrl.zhi_out   = 1'b1;
          ctrl.hi_enable = 1'b1;
          state_d        = ctrl_io.stop ? StHalt : StT0;
        end
        StHalt: begin
          state_d = StHalt;
        end
      endcase
    end
  end

  reg_select u_r_out_sel (
    .sel_i    (out_sel),
    .en_i     (out_en),
    .onehot_o (ctrl_io.r_out)
  );

  reg_select u_r_in_sel (
    .sel_i    (ra),
    .en_i     (in_en),
    .onehot_o (ctrl_io.r_in)
  );

  // pc_enable stays low until branch support exists; ctrl.pc_enable is never set.
  assign ctrl_io.pc_out       = ctrl.pc_out;
  assign ctrl_io.zlo_out      = ctrl.zlo_out;
  assign ctrl_io.zhi_out      = ctrl.zhi_out;
  assign ctrl_io.mdr_out      = ctrl.mdr_out;
  assign ctrl_io.mar_enable   = ctrl.mar_enable;
  assign ctrl_io.z_enable     = ctrl.z_enable;
  assign ctrl_io.pc_enable    = ctrl.pc_enable;
  assign ctrl_io.mdr_enable   = ctrl.mdr_enable;
  assign ctrl_io.ir_enable    = ctrl.ir_enable;
  assign ctrl_io.y_enable     = ctrl.y_enable;
  assign ctrl_io.pc_increment = ctrl.pc_increment;
  assign ctrl_io.read         = ctrl.read;
  assign ctrl_io.lo_enable    = ctrl.lo_enable;
  assign ctrl_io.hi_enable    = ctrl.hi_enable;
  assign ctrl_io.op_code      = op_code;
  assign ctrl_io.run          = active_q && (state_q != StHalt);
  assign ctrl_io.illegal      = illegal_q;

endmodule
